// File: rtl/updown_pattern_pkg.sv
// Shared types and constant tables for the up/down "double-4" pattern checker.
// The period is 0,1,2,3,4,5,6,7,6,5,4,4,3,2,1. Index 11 is the repeated 4.
package updown_pattern_pkg;

  typedef enum logic [1:0] {
    PH_UP   = 2'd0,
    PH_DOWN = 2'd1,
    PH_DUP4 = 2'd2,
    PH_NONE = 2'd3
  } ph_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int         SEQ_LEN = 15;
  localparam logic [3:0] IDX_MAX = 4'd14;

  localparam logic [2:0] SEQ [SEQ_LEN] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd6, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1
  };

  localparam ph_t PH_TAB [SEQ_LEN] = '{
    PH_UP,   PH_UP,   PH_UP,   PH_UP,   PH_UP,   PH_UP,   PH_UP,   PH_UP,
    PH_DOWN, PH_DOWN, PH_DOWN, PH_DUP4, PH_DOWN, PH_DOWN, PH_DOWN
  };

endpackage

// File: rtl/updown_seq_rom.sv
// Combinational lookup from a period index to the expected count and its phase.
module updown_seq_rom
  import updown_pattern_pkg::*;
(
  input  logic [3:0] idx,
  output logic [2:0] exp,
  output ph_t        phase
);

  // Table lookup; an index past the end of the period yields a neutral entry
  always_comb begin
    exp   = 3'd0;
    phase = PH_NONE;
    if (idx <= IDX_MAX) begin
      exp   = SEQ[idx];
      phase = PH_TAB[idx];
    end else begin
      exp   = 3'd0;
      phase = PH_NONE;
    end
  end

endmodule

// File: rtl/updown_pattern_checker.sv
// Receive-side checker for the up/down "double-4" counter stream.
// Hunts for the 0 anchor, confirms LOCK_LEN further matches, then flywheels
// through the period flagging every deviation. All outputs are registered.
// Optional build macro: UPDOWN_CHK_CAPTURE_EN adds cap_valid/cap_exp/cap_got,
// which hold the expected and received values of the first locked mismatch.
module updown_pattern_checker
  import updown_pattern_pkg::*;
#(
  parameter int LOCK_LEN      = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cnt_in,
  input  logic             in_valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output ph_t              phase,
  output logic [ERR_W-1:0] err_count
`ifdef UPDOWN_CHK_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [2:0]       cap_exp,
  output logic [2:0]       cap_got
`endif
);

  localparam int CW_M = $clog2(LOCK_LEN + 1);
  localparam int CW_U = $clog2(UNLOCK_MISSES + 1);

  localparam logic [CW_M-1:0]  M_ONE    = CW_M'(1'b1);
  localparam logic [CW_M-1:0]  M_ZERO   = CW_M'(1'b0);
  localparam logic [CW_M-1:0]  LOCK_TGT = CW_M'(LOCK_LEN);
  localparam logic [CW_U-1:0]  U_ONE    = CW_U'(1'b1);
  localparam logic [CW_U-1:0]  U_ZERO   = CW_U'(1'b0);
  localparam logic [CW_U-1:0]  MISS_TGT = CW_U'(UNLOCK_MISSES);
  localparam logic [ERR_W-1:0] E_ONE    = ERR_W'(1'b1);
  localparam logic [ERR_W-1:0] E_MAX    = {ERR_W{1'b1}};

  chk_state_t       state_r, state_s;
  logic [3:0]       idx_r, idx_s;
  logic [CW_M-1:0]  match_r, match_s, match_inc_s;
  logic [CW_U-1:0]  miss_r, miss_s, miss_inc_s;
  logic [3:0]       nxt_idx_s;
  logic [2:0]       exp_s;
  ph_t              nxt_ph_s;
  ph_t              phase_s;
  logic             err_s, wrap_s, cap_hit_s;
  logic [ERR_W-1:0] err_cnt_s;

  // Position the next sample should occupy, wrapping at the end of the period
  always_comb begin
    nxt_idx_s = 4'd0;
    if (idx_r == IDX_MAX) begin
      nxt_idx_s = 4'd0;
    end else begin
      nxt_idx_s = idx_r + 4'd1;
    end
  end

  updown_seq_rom u_rom (
    .idx   (nxt_idx_s),
    .exp   (exp_s),
    .phase (nxt_ph_s)
  );

  assign match_inc_s = match_r + M_ONE;
  assign miss_inc_s  = miss_r + U_ONE;

  // Next-state and next-output logic; everything holds when no sample arrives
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    match_s   = match_r;
    miss_s    = miss_r;
    phase_s   = phase;
    err_cnt_s = err_count;
    err_s     = 1'b0;
    wrap_s    = 1'b0;
    cap_hit_s = 1'b0;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (cnt_in == 3'd0) begin
            idx_s   = 4'd0;
            match_s = M_ZERO;
            phase_s = PH_UP;
            state_s = SYNC;
          end else begin
            state_s = HUNT;
          end
        end
        SYNC: begin
          if (cnt_in == exp_s) begin
            idx_s   = nxt_idx_s;
            match_s = match_inc_s;
            phase_s = nxt_ph_s;
            if (match_inc_s == LOCK_TGT) begin
              state_s = LOCKED;
              miss_s  = U_ZERO;
            end else begin
              state_s = SYNC;
            end
          end else if (cnt_in == 3'd0) begin
            // A stray 0 is treated as a fresh anchor rather than a failure
            idx_s   = 4'd0;
            match_s = M_ZERO;
            phase_s = PH_UP;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the position advances whether or not the sample agrees
          idx_s   = nxt_idx_s;
          phase_s = nxt_ph_s;
          if (cnt_in == exp_s) begin
            miss_s = U_ZERO;
            wrap_s = (nxt_idx_s == 4'd0);
          end else begin
            err_s     = 1'b1;
            cap_hit_s = 1'b1;
            if (err_count != E_MAX) begin
              err_cnt_s = err_count + E_ONE;
            end else begin
              err_cnt_s = err_count;
            end
            if (miss_inc_s == MISS_TGT) begin
              miss_s  = U_ZERO;
              state_s = HUNT;
            end else begin
              miss_s = miss_inc_s;
            end
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= HUNT;
      idx_r     <= 4'd0;
      match_r   <= M_ZERO;
      miss_r    <= U_ZERO;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      phase     <= PH_NONE;
      err_count <= {ERR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      match_r   <= match_s;
      miss_r    <= miss_s;
      locked    <= (state_s == LOCKED);
      err       <= err_s;
      wrap      <= wrap_s;
      phase     <= phase_s;
      err_count <= err_cnt_s;
    end
  end

`ifdef UPDOWN_CHK_CAPTURE_EN
  // Latch the first locked mismatch since reset; later ones are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_exp   <= 3'd0;
      cap_got   <= 3'd0;
    end else if (cap_hit_s && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_exp   <= exp_s;
      cap_got   <= cnt_in;
    end else begin
      cap_valid <= cap_valid;
      cap_exp   <= cap_exp;
      cap_got   <= cap_got;
    end
  end
`endif

endmodule

// File: tb/tb_updown_pattern_checker.sv
// Self-checking bench for updown_pattern_checker: directed scenarios plus a
// randomized soak, all checked against a behavioural model of the stream
// rules. A second instance with ERR_W=2 checks saturation of the error count.
module tb_updown_pattern_checker;

  localparam int LOCK_LEN      = 4;
  localparam int UNLOCK_MISSES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cnt_in = 3'd0;
  logic       in_valid = 1'b0;

  logic       locked, err, wrap;
  logic [1:0] phase;
  logic [7:0] err_count;
  logic       locked2, err2, wrap2;
  logic [1:0] phase2;
  logic [1:0] err_count2;
`ifdef UPDOWN_CHK_CAPTURE_EN
  logic       cap_valid, cap_valid2;
  logic [2:0] cap_exp, cap_got, cap_exp2, cap_got2;
`endif

  updown_pattern_checker #(.LOCK_LEN(LOCK_LEN), .UNLOCK_MISSES(UNLOCK_MISSES), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .in_valid(in_valid),
    .locked(locked), .err(err), .wrap(wrap), .phase(phase), .err_count(err_count)
`ifdef UPDOWN_CHK_CAPTURE_EN
    , .cap_valid(cap_valid), .cap_exp(cap_exp), .cap_got(cap_got)
`endif
  );

  updown_pattern_checker #(.LOCK_LEN(LOCK_LEN), .UNLOCK_MISSES(UNLOCK_MISSES), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .in_valid(in_valid),
    .locked(locked2), .err(err2), .wrap(wrap2), .phase(phase2), .err_count(err_count2)
`ifdef UPDOWN_CHK_CAPTURE_EN
    , .cap_valid(cap_valid2), .cap_exp(cap_exp2), .cap_got(cap_got2)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 searching, 1 confirming, 2 locked
  int m_mode = 0, m_pos = 0, m_run = 0, m_miss = 0;
  int m_locked = 0, m_err = 0, m_wrap = 0, m_phase = 3;
  int m_cnt8 = 0, m_cnt2 = 0;
  int m_cap_v = 0, m_cap_e = 0, m_cap_g = 0;

  // Value of the stream at position p of the 15-sample period
  function automatic int seq_at(input int p);
    if (p <= 7) return p;
    else if (p <= 10) return 14 - p;
    else if (p == 11) return 4;
    else return 15 - p;
  endfunction

  // Phase code of position p: 0 up, 1 down, 2 repeated four
  function automatic int phase_of(input int p);
    if (p == 11) return 2;
    else if (p <= 7) return 0;
    else return 1;
  endfunction

  task automatic model_step(input bit r, input bit v, input int val);
    int nxt;
    int e;
    m_err  = 0;
    m_wrap = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_run = 0; m_miss = 0; m_phase = 3;
      m_cnt8 = 0; m_cnt2 = 0; m_cap_v = 0; m_cap_e = 0; m_cap_g = 0;
    end else if (v) begin
      nxt = (m_pos + 1) % 15;
      e   = seq_at(nxt);
      if (m_mode == 0) begin
        if (val == 0) begin
          m_mode = 1; m_pos = 0; m_run = 0; m_phase = phase_of(0);
        end
      end else if (m_mode == 1) begin
        if (val == e) begin
          m_pos = nxt; m_run = m_run + 1; m_phase = phase_of(nxt);
          if (m_run == LOCK_LEN) begin
            m_mode = 2; m_miss = 0;
          end
        end else if (val == 0) begin
          m_pos = 0; m_run = 0; m_phase = phase_of(0);
        end else begin
          m_mode = 0;
        end
      end else begin
        m_pos = nxt;
        m_phase = phase_of(nxt);
        if (val == e) begin
          m_miss = 0;
          m_wrap = (nxt == 0) ? 1 : 0;
        end else begin
          m_err = 1;
          if (m_cap_v == 0) begin
            m_cap_v = 1; m_cap_e = e; m_cap_g = val;
          end
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
          m_miss = m_miss + 1;
          if (m_miss == UNLOCK_MISSES) begin
            m_mode = 0; m_miss = 0;
          end
        end
      end
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s at vector %0d: observed %0d expected %0d", tag, vectors, got, expv);
    end
  endtask

  // One clock: drive inputs, advance model, sample outputs #1 after the edge
  task automatic step(input bit r, input bit v, input int val);
    rst = r;
    in_valid = v;
    cnt_in = 3'(val);
    @(posedge clk);
    model_step(r, v, val);
    #1;
    vectors++;
    check("locked", {31'd0, locked}, m_locked);
    check("err", {31'd0, err}, m_err);
    check("wrap", {31'd0, wrap}, m_wrap);
    check("phase", {30'd0, phase}, m_phase);
    check("err_count", {24'd0, err_count}, m_cnt8);
    check("err_count_w2", {30'd0, err_count2}, m_cnt2);
    check("locked_w2", {31'd0, locked2}, m_locked);
`ifdef UPDOWN_CHK_CAPTURE_EN
    check("cap_valid", {31'd0, cap_valid}, m_cap_v);
    check("cap_exp", {29'd0, cap_exp}, m_cap_e);
    check("cap_got", {29'd0, cap_got}, m_cap_g);
`endif
  endtask

  task automatic send(input int val);
    step(1'b0, 1'b1, val);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_phase", {30'd0, phase}, 3);
    check("rst_err_count", {24'd0, err_count}, 0);
  endtask

  task automatic lock_clean();
    for (int i = 0; i < 15; i++) send(seq_at(i));
  endtask

  initial begin
    int errs;
    int wraps;
    int t4 [19];
    int g;
    int v;
    int val;

    // 1: clean stream from reset
    do_reset();
    errs = 0; wraps = 0;
    for (int i = 0; i < 45; i++) begin
      send(seq_at(i % 15));
      if (i == 3) check("t1_prelock", {31'd0, locked}, 0);
      if (i == 4) check("t1_lock", {31'd0, locked}, 1);
      errs += int'(err);
      wraps += int'(wrap);
    end
    check("t1_errs", errs, 0);
    check("t1_wraps", wraps, 2);

    // 2: stream joined mid-period
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(seq_at((i + 5) % 15));
      check("t2_lock", {31'd0, locked}, (i == 14) ? 1 : 0);
    end

    // 3: single corrupted repeated-four while locked
    do_reset();
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      send((i == 26) ? 5 : seq_at(i % 15));
      errs += int'(err);
    end
    check("t3_errs", errs, 1);
    check("t3_err_count", {24'd0, err_count}, 1);
    check("t3_locked", {31'd0, locked}, 1);
`ifdef UPDOWN_CHK_CAPTURE_EN
    check("t3_cap_exp", {29'd0, cap_exp}, 4);
    check("t3_cap_got", {29'd0, cap_got}, 5);
`endif

    // 4: repeated four removed, drop lock, re-anchor on next 0
    do_reset();
    lock_clean();
    t4 = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4};
    errs = 0;
    for (int i = 0; i < 19; i++) begin
      send(t4[i]);
      errs += int'(err);
      if (i == 13) begin
        check("t4_unlock", {31'd0, locked}, 0);
        check("t4_err_count", {24'd0, err_count}, 3);
      end
      if (i == 14) check("t4_anchor_phase", {30'd0, phase}, 0);
    end
    check("t4_errs", errs, 3);
    check("t4_relock", {31'd0, locked}, 1);

    // 5: random idle gaps between samples
    do_reset();
    lock_clean();
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, 5);
        for (int k = 0; k < g; k++) begin
          step(1'b0, 1'b0, $urandom_range(0, 7));
          errs += int'(err);
        end
      end
      send(seq_at(i % 15));
      errs += int'(err);
    end
    check("t5_errs", errs, 0);
    check("t5_locked", {31'd0, locked}, 1);

    // 6: five isolated errors saturate the 2-bit counter; then mid-stream reset
    do_reset();
    lock_clean();
    for (int p = 0; p < 5; p++) begin
      g = $urandom_range(0, 14);
      for (int i = 0; i < 15; i++) begin
        val = seq_at(i);
        if (i == g) val = (val + 1 + $urandom_range(0, 6)) % 8;
        send(val);
      end
    end
    check("t6_err_count8", {24'd0, err_count}, 5);
    check("t6_err_count2", {30'd0, err_count2}, 3);
    check("t6_locked", {31'd0, locked}, 1);
    step(1'b1, 1'b1, 1);
    check("t6_rst_locked", {31'd0, locked}, 0);
    check("t6_rst_err_count", {24'd0, err_count}, 0);
    check("t6_rst_err_count2", {30'd0, err_count2}, 0);

    // Randomized soak: mostly well-formed stream with corruption and stalls
    g = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) != 0) ? 1 : 0;
      val = ($urandom_range(0, 9) < 8) ? seq_at(g) : $urandom_range(0, 7);
      if (v == 1) g = (g + 1) % 15;
      step(1'b0, v[0], val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
